// File: rtl/hb2_pkg.sv
// hb2_pkg: constants shared by the WD16 engine and its mixing stage.
//   WORD_W / KEY_W : datapath word width and round-key bundle width.
//   IDLE/RUN/CAPT/OUT : engine FSM state encoding.
//   KEY_*_LSB      : bit position of each 16-bit round key inside key_in.
//   key_word()     : selects round key a, b, c or d for round 0..3.
package hb2_pkg;

  localparam int WORD_W = 16;
  localparam int KEY_W  = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam int KEY_A_LSB = 48;
  localparam int KEY_B_LSB = 32;
  localparam int KEY_C_LSB = 16;
  localparam int KEY_D_LSB = 0;

  function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key,
                                                 input logic [1:0]       r);
    logic [WORD_W-1:0] k;
    k = key[KEY_D_LSB +: WORD_W];
    case (r)
      2'd0:    k = key[KEY_A_LSB +: WORD_W];
      2'd1:    k = key[KEY_B_LSB +: WORD_W];
      2'd2:    k = key[KEY_C_LSB +: WORD_W];
      default: k = key[KEY_D_LSB +: WORD_W];
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mix_func.sv
// mix_func: Hummingbird-2 mixing function f(x) = L(S(x)).
//   S applies four 4-bit S-boxes (S1 on the top nibble down to S4 on the
//   bottom nibble) and is registered; L(y) = y ^ rotl6(y) ^ rotl10(y) is
//   combinational on the registered S-box word.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   in_word   : word to mix, sampled on the rising edge
//   out_word  : f(in_word) one cycle after in_word was presented
module mix_func
  import hb2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  output logic [WORD_W-1:0] out_word
);

  // Each table packs entry n at bits [4n+3:4n].
  localparam logic [63:0] S1_TAB = 64'h3A840D6BF5129EC7;
  localparam logic [63:0] S2_TAB = 64'h2B95DE03C7F861A4;
  localparam logic [63:0] S3_TAB = 64'h79B0438EDA651CF2;
  localparam logic [63:0] S4_TAB = 64'hBDC6E03A1279854F;

  function automatic logic [3:0] sbox(input logic [63:0] tab, input logic [3:0] nib);
    return tab[{nib, 2'b00} +: 4];
  endfunction

  logic [WORD_W-1:0] sbox_d;
  logic [WORD_W-1:0] sbox_q;

  always_comb begin
    sbox_d = {sbox(S1_TAB, in_word[15:12]),
              sbox(S2_TAB, in_word[11:8]),
              sbox(S3_TAB, in_word[7:4]),
              sbox(S4_TAB, in_word[3:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbox_q <= '0;
    end else begin
      sbox_q <= sbox_d;
    end
  end

  // Linear layer on the registered S-box output.
  always_comb begin
    out_word = sbox_q
             ^ {sbox_q[9:0], sbox_q[15:10]}
             ^ {sbox_q[5:0], sbox_q[15:6]};
  end

endmodule

// File: rtl/wd16_engine.sv
// wd16_engine: computes WD16(x,a,b,c,d) = f(f(f(f(x^a)^b)^c)^d) with a single
// shared mix_func, one round per cycle, behind valid/ready handshakes.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid / in_ready : request handshake; x_in and key_in captured on accept
//   x_in                : 16-bit word to process
//   key_in              : round keys {a,b,c,d}, a in the top 16 bits
//   out_valid/out_ready : result handshake; word_out held until accepted
//   word_out            : WD16 result (keeps last value after handshake)
module wd16_engine
  import hb2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] x_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] word_out
);

  logic [1:0]        state_d, state_q;
  logic [1:0]        r_d, r_q;
  logic [WORD_W-1:0] x_d, x_q;
  logic [KEY_W-1:0]  key_d, key_q;
  logic [WORD_W-1:0] word_d, word_q;
  logic              out_valid_d, out_valid_q;
  logic              accept;
  logic [WORD_W-1:0] mix_in;
  logic [WORD_W-1:0] mixed_word;

  mix_func u_mix (
    .clk      (clk),
    .rst      (rst),
    .in_word  (mix_in),
    .out_word (mixed_word)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    x_d         = x_q;
    key_d       = key_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;

    in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    accept   = in_valid && in_ready;

    // Round 0 starts from the captured word; later rounds chain the previous
    // f() output, which is valid exactly one cycle after its input.
    mix_in = ((r_q == 2'd0) ? x_q : mixed_word) ^ key_word(key_q, r_q);

    case (state_q)
      RUN: begin
        if (r_q == 2'd3) begin
          state_d = CAPT;
          r_d     = 2'd0;
        end else begin
          r_d = r_q + 2'd1;
        end
      end
      CAPT: begin
        word_d      = mixed_word;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = state_q;
    endcase

    // Acceptance from IDLE or straight out of OUT (back-to-back) both start
    // a new operation at round 0.
    if (accept) begin
      x_d     = x_in;
      key_d   = key_in;
      r_d     = 2'd0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= 2'd0;
      x_q         <= '0;
      key_q       <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      x_q         <= x_d;
      key_q       <= key_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign word_out  = word_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wd16_engine.sv
// Testbench for wd16_engine: directed scenarios plus a randomized request
// stream, all checked against a cycle-level behavioural model and an
// in-order scoreboard of software WD16 results.
module tb_wd16_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [63:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wd16_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_out  (word_out)
  );

  // Hummingbird-2 S-boxes, listed by input value 0..15.
  int S1 [16] = '{7, 12, 14, 9, 2, 1, 5, 15, 11, 6, 13, 0, 4, 8, 10, 3};
  int S2 [16] = '{4, 10, 1, 6, 8, 15, 7, 12, 3, 0, 14, 13, 5, 9, 11, 2};
  int S3 [16] = '{2, 15, 12, 1, 5, 6, 10, 13, 14, 8, 3, 4, 0, 11, 9, 7};
  int S4 [16] = '{15, 4, 5, 8, 9, 7, 2, 1, 10, 3, 0, 14, 6, 12, 13, 11};

  function automatic logic [15:0] f_model(input logic [15:0] w);
    int s, r6, r10;
    s   = S1[w[15:12]] * 4096 + S2[w[11:8]] * 256 + S3[w[7:4]] * 16 + S4[w[3:0]];
    r6  = ((s * 64) % 65536) + s / 1024;
    r10 = ((s * 1024) % 65536) + s / 64;
    return 16'(s ^ r6 ^ r10);
  endfunction

  function automatic logic [15:0] wd16_model(input logic [15:0] x, input logic [63:0] key);
    logic [15:0] w;
    logic [63:0] k;
    w = x;
    for (int i = 0; i < 4; i++) begin
      k = key >> (48 - 16 * i);
      w = f_model(w ^ k[15:0]);
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a request becomes visible 5 edges after acceptance and
  // stays until out_ready is seen; the block is busy from acceptance until then.
  bit          chk_en     = 1'b0;
  bit          m_inflight = 1'b0;
  bit          m_holding  = 1'b0;
  int          m_age      = 0;
  logic [15:0] m_pend     = 16'h0;
  logic [15:0] m_word     = 16'h0;
  logic [15:0] sb_q [$];
  int          acc_cnt    = 0;
  int          hs_cnt     = 0;
  int          dropped    = 0;

  always @(negedge clk) begin
    bit          exp_ready;
    logic [15:0] e;
    exp_ready = !(m_inflight || m_holding) || (m_holding && out_ready);
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(m_holding));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("word_out", 64'(word_out), 64'(m_word));
    end
    if (rst) begin
      m_inflight = 1'b0;
      m_holding  = 1'b0;
      m_age      = 0;
      m_word     = 16'h0;
      dropped    = dropped + sb_q.size();
      sb_q.delete();
    end else begin
      if (m_holding && out_ready) begin
        m_holding = 1'b0;
        hs_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_extra_result", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check("sb_order", 64'(word_out), 64'(e));
        end
      end
      if (m_inflight) begin
        m_age++;
        if (m_age == 5) begin
          m_inflight = 1'b0;
          m_holding  = 1'b1;
          m_word     = m_pend;
        end
      end
      if (in_valid && exp_ready) begin
        m_inflight = 1'b1;
        m_age      = 0;
        m_pend     = wd16_model(x_in, key_in);
        sb_q.push_back(m_pend);
        acc_cnt++;
      end
    end
  end

  initial begin
    int base;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = 16'h0;
    key_in    = 64'h0;

    // Pin the model to hand-derived values.
    check("model_f0", 64'(f_model(16'h0000)), 64'h0000_0000_0000_C222);
    check("model_wd16_zero", 64'(wd16_model(16'h0000, 64'h0)), 64'h0000_0000_0000_A8AE);
    check("model_wd16_c222", 64'(wd16_model(16'h1234, 64'h1234_C222_C222_C222)),
          64'h0000_0000_0000_C222);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_word_out", 64'(word_out), 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // All-zero request with inputs scrambled while it runs
    x_in     = 16'h0000;
    key_in   = 64'h0;
    in_valid = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      x_in      = 16'($urandom);
      key_in    = {$urandom, $urandom};
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      step();
      if (i < 5) check("lat_no_valid", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    check("lat5_valid", 64'(out_valid), 64'd1);
    check("res_zero", 64'(word_out), 64'h0000_0000_0000_A8AE);

    // Backpressure hold for 10 cycles
    for (int i = 0; i < 10; i++) begin
      x_in     = 16'($urandom);
      key_in   = {$urandom, $urandom};
      in_valid = 1'($urandom % 2);
      step();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_word", 64'(word_out), 64'h0000_0000_0000_A8AE);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end

    // Back-to-back acceptance on the handshake edge
    x_in      = 16'h1234;
    key_in    = 64'h1234_C222_C222_C222;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bb_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bb_valid_clr", 64'(out_valid), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("bb_no_valid", 64'(out_valid), 64'd0);
    end
    step();
    check("bb_valid", 64'(out_valid), 64'd1);
    check("bb_word", 64'(word_out), 64'h0000_0000_0000_C222);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_word", 64'(word_out), 64'h0000_0000_0000_C222);
    check("post_hs_ready", 64'(in_ready), 64'd1);

    // Reset in RUN round 2 discards the operation
    x_in     = 16'($urandom);
    key_in   = {$urandom, $urandom};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_word", 64'(word_out), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_rst_no_result", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

    // Random stream of 1000 requests with random backpressure
    base = acc_cnt;
    cyc  = 0;
    while ((acc_cnt - base) < 1000 && cyc < 60000) begin
      in_valid  = (($urandom % 4) != 0);
      x_in      = 16'($urandom);
      key_in    = {$urandom, $urandom};
      out_ready = 1'($urandom % 2);
      step();
      cyc++;
    end
    check("rand_accepted", 64'(acc_cnt - base), 64'd1000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc       = 0;
    while ((sb_q.size() != 0 || out_valid) && cyc < 50) begin
      step();
      cyc++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    check("hs_count", 64'(hs_cnt), 64'(acc_cnt - dropped));
    check("dropped_count", 64'(dropped), 64'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
